// File: rtl/change_dispenser_if.sv
// Request/dispense bus between the vend controller (master) and the change dispenser (slave).
interface change_dispenser_if #(
  parameter int AMT_W    = 4,
  parameter int HOPPER_W = 4
);
  logic                req;
  logic [AMT_W-1:0]    amount;
  logic                refill;
  logic                ready;
  logic                coin_out;
  logic                done;
  logic                fault;
  logic [HOPPER_W-1:0] coin_count;

  modport master (
    output req, amount, refill,
    input  ready, coin_out, done, fault, coin_count
  );

  modport slave (
    input  req, amount, refill,
    output ready, coin_out, done, fault, coin_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Dollar-coin payout controller: one timed solenoid pulse per coin owed,
// with hopper inventory tracking and rejection of requests it cannot cover.
module change_dispenser #(
  parameter int AMT_W        = 4,
  parameter int HOPPER_W     = 4,
  parameter int HOPPER_MAX   = 15,
  parameter int HOPPER_INIT  = 0,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  change_dispenser_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int CMP_W  = (AMT_W > HOPPER_W) ? AMT_W : HOPPER_W;

  localparam logic [PH_W-1:0]     PH_PULSE = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]     PH_GAP   = PH_W'(GAP_CYCLES - 1);
  localparam logic [PH_W-1:0]     PH_ZERO  = {PH_W{1'b0}};
  localparam logic [HOPPER_W-1:0] CNT_MAX  = HOPPER_W'(HOPPER_MAX);
  localparam logic [HOPPER_W-1:0] CNT_INIT = HOPPER_W'(HOPPER_INIT);
  localparam logic [HOPPER_W-1:0] CNT_ONE  = {{(HOPPER_W-1){1'b0}}, 1'b1};
  localparam logic [AMT_W-1:0]    AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0]    AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_e              state_q,  state_d;
  logic [AMT_W-1:0]    remain_q, remain_d;
  logic [PH_W-1:0]     phase_q,  phase_d;
  logic                fault_q,  fault_d;
  logic [HOPPER_W-1:0] count_q,  count_d;

  logic [CMP_W-1:0]    amt_ext_s;
  logic [CMP_W-1:0]    cnt_ext_s;
  logic                dispense_s;

  // Compare against the inventory as registered, so a same-edge refill does not count.
  assign amt_ext_s  = CMP_W'(bus.amount);
  assign cnt_ext_s  = CMP_W'(count_q);
  assign dispense_s = (state_q == ST_PULSE) && (phase_q == PH_ZERO);

  // Next-state, remaining-coin and phase counter logic.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    phase_d  = phase_q;
    fault_d  = fault_q;
    case (state_q)
      ST_IDLE: begin
        fault_d = 1'b0;
        if (bus.req) begin
          remain_d = bus.amount;
          if (bus.amount == AMT_ZERO) begin
            state_d = ST_DONE;
          end else if (amt_ext_s > cnt_ext_s) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else begin
            state_d = ST_PULSE;
            phase_d = PH_PULSE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (phase_q == PH_ZERO) begin
          remain_d = remain_q - AMT_ONE;
          if (remain_q == AMT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
            phase_d = PH_GAP;
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (phase_q == PH_ZERO) begin
          state_d = ST_PULSE;
          phase_d = PH_PULSE;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        remain_d = AMT_ZERO;
        phase_d  = PH_ZERO;
        fault_d  = 1'b0;
      end
    endcase
  end

  // Hopper inventory: a refill coinciding with a dispensed coin cancels out.
  always_comb begin
    count_d = count_q;
    if (dispense_s && bus.refill) begin
      count_d = count_q;
    end else if (dispense_s) begin
      count_d = count_q - CNT_ONE;
    end else if (bus.refill && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      remain_q <= AMT_ZERO;
      phase_q  <= PH_ZERO;
      fault_q  <= 1'b0;
      count_q  <= CNT_INIT;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      phase_q  <= phase_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.coin_out   = (state_q == ST_PULSE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.fault      = (state_q == ST_DONE) && fault_q;
  assign bus.coin_count = count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboarded bench for change_dispenser: per-cycle timing model plus a done-time checker.
module tb_change_dispenser;

  localparam int P     = 4;
  localparam int G     = 2;
  localparam int HMAX  = 15;
  localparam int HINIT = 0;

  typedef struct {
    bit flt;
    int coins;
    int cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  int   cnt_m;
  exp_t exp_q[$];

  change_dispenser_if #(.AMT_W(4), .HOPPER_W(4)) dut_if ();

  change_dispenser #(
    .AMT_W(4), .HOPPER_W(4), .HOPPER_MAX(HMAX), .HOPPER_INIT(HINIT),
    .PULSE_CYCLES(P), .GAP_CYCLES(G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Done-time checker: pops the expected outcome and compares fault, coins paid and inventory.
  initial begin : monitor
    int   coins;
    logic prev;
    exp_t e;
    coins = 0;
    prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        coins = 0;
        prev  = 1'b0;
      end else begin
        if (dut_if.coin_out && !prev) coins++;
        prev = dut_if.coin_out;
        if (dut_if.done) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_done", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("sb_fault", dut_if.fault, e.flt);
            check_eq("sb_coins", coins, e.coins);
            check_eq("sb_count", dut_if.coin_count, e.cnt);
          end
          coins = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic do_refill(input int n);
    @(negedge clk);
    dut_if.refill = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    dut_if.refill = 1'b0;
    cnt_m = (cnt_m + n > HMAX) ? HMAX : cnt_m + n;
    @(negedge clk);
    check_eq("refill_count", dut_if.coin_count, cnt_m);
  endtask

  // Waits for ready, drives the request and pushes the expected outcome; returns just after the accept edge.
  task automatic start_req(input int amt, input bit hold, input int adj, output int n_o, output bit flt_o);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!dut_if.ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_wait", dut_if.ready, 1);
    flt_o   = (amt != 0) && (amt > cnt_m);
    n_o     = flt_o ? 0 : amt;
    e.flt   = flt_o;
    e.coins = n_o;
    e.cnt   = cnt_m - n_o + adj;
    exp_q.push_back(e);
    dut_if.req    = 1'b1;
    dut_if.amount = 4'(amt);
    @(posedge clk);
    #1;
    if (!hold) begin
      dut_if.req    = 1'b0;
      dut_if.amount = 4'd0;
    end
  endtask

  // Full request with cycle-accurate checks; rf_cyc>0 pulses refill in that (pulse-ending) cycle.
  task automatic run_req(input int amt, input int rf_cyc);
    int n, last, cnt0, adj, done_coins, base;
    bit flt, exp_coin;
    cnt0 = cnt_m;
    adj  = (rf_cyc > 0) ? 1 : 0;
    start_req(amt, 1'b0, adj, n, flt);
    last = (n == 0) ? 1 : n * P + (n - 1) * G + 1;
    for (int c = 1; c <= last + 1; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      dut_if.refill = (c == rf_cyc);
      @(negedge clk);
      exp_coin   = 1'b0;
      done_coins = 0;
      for (int k = 1; k <= n; k++) begin
        base = (k - 1) * (P + G);
        if (c >= base + 1 && c <= base + P) exp_coin = 1'b1;
        if (c > base + P) done_coins++;
      end
      check_eq($sformatf("coin_out a%0d c%0d", amt, c), dut_if.coin_out, exp_coin);
      check_eq($sformatf("done a%0d c%0d", amt, c), dut_if.done, c == last);
      check_eq($sformatf("fault a%0d c%0d", amt, c), dut_if.fault, flt && (c == last));
      check_eq($sformatf("ready a%0d c%0d", amt, c), dut_if.ready, c == last + 1);
      check_eq($sformatf("count a%0d c%0d", amt, c), dut_if.coin_count,
               cnt0 - done_coins + ((rf_cyc > 0 && c > rf_cyc) ? 1 : 0));
    end
    dut_if.refill = 1'b0;
    cnt_m = cnt0 - n + adj;
  endtask

  initial begin : stim
    int   n, c, waited;
    bit   flt, seen;
    exp_t e;
    n_total = 0;
    n_bad   = 0;
    cnt_m   = HINIT;
    rst_n   = 1'b0;
    dut_if.req    = 1'b0;
    dut_if.amount = 4'd0;
    dut_if.refill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", dut_if.ready, 1);
    check_eq("rst_coin", dut_if.coin_out, 0);
    check_eq("rst_done", dut_if.done, 0);
    check_eq("rst_fault", dut_if.fault, 0);
    check_eq("rst_count", dut_if.coin_count, HINIT);
    rst_n = 1'b1;

    do_refill(3);
    run_req(2, 0);
    do_refill(4);
    run_req(0, 0);
    run_req(4, 0);
    run_req(2, 0);
    run_req(1, 0);
    do_refill(20);
    run_req(8, 0);
    run_req(1, 4);

    // Reset asserted in cycle 8 of an amount=3 request.
    start_req(3, 1'b0, 0, n, flt);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      check_eq($sformatf("rst_mid_coin c%0d", k), dut_if.coin_out, (k <= 4) || (k == 7));
    end
    @(posedge clk);
    #1;
    check_eq("rst_mid_coin c8", dut_if.coin_out, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_coin_drop", dut_if.coin_out, 0);
    check_eq("rst_mid_ready", dut_if.ready, 1);
    check_eq("rst_mid_done", dut_if.done, 0);
    check_eq("rst_mid_count", dut_if.coin_count, HINIT);
    exp_q.delete();
    cnt_m = HINIT;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_done", dut_if.done, 0);
      check_eq("post_rst_ready", dut_if.ready, 1);
    end
    do_refill(3);
    run_req(2, 0);

    // req held high with amount changed mid-transfer, then back-to-back acceptance.
    do_refill(8);
    start_req(2, 1'b1, 0, n, flt);
    c    = 1;
    seen = 1'b0;
    while (!seen && c < 60) begin
      if (c == 3) dut_if.amount = 4'd5;
      @(negedge clk);
      if (dut_if.done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    check_eq("hold_done_cyc", c, 11);
    cnt_m   = cnt_m - 2;
    e.flt   = 1'b0;
    e.coins = 5;
    e.cnt   = cnt_m - 5;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("b2b_ready", dut_if.ready, 1);
    @(posedge clk);
    #1;
    dut_if.req    = 1'b0;
    dut_if.amount = 4'd0;
    @(negedge clk);
    check_eq("b2b_coin", dut_if.coin_out, 1);
    check_eq("b2b_busy", dut_if.ready, 0);
    cnt_m  = cnt_m - 5;
    waited = 0;
    @(negedge clk);
    while (!dut_if.ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("b2b_finish", dut_if.ready, 1);
    check_eq("b2b_count", dut_if.coin_count, cnt_m);

    repeat (5) @(negedge clk);
    check_eq("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
